sc_stream_gen: RTL
==================

# sc_stream_gen

Binary-to-stochastic stream generator for the stochastic-computing datapath. It latches four 4-bit signed bipolar operands and emits one stochastic bit per lane per cycle for a programmable stream length. It then pulses done and returns to idle. It is the transmitting end of the up/down-counter accumulator interface: a counter that counts +1 on a 1 and −1 on a 0 over one full 16-cycle stream recovers exactly 2·x per lane.

## Interface
Parameters:
- SEED, 4'b0000, RNG state loaded at stream start.

Ports:
- i_clk_sng  input  1  clock, rising edge.
- i_rst_sng  input  1  reset, asynchronous, active-high.
- i_start_sng  input  1  start request; sampled only in IDLE.
- i_stop_sng  input  1  abort; ends an active stream.
- i_x_sng  input  4×[3:0]  lane operands, two's complement, −8..7.
- i_len_sng  input  [3:0]  stream length minus one (L = i_len_sng + 1, 1..16).
- o_isgen  output  1  high while the stream bits are valid.
- o_sn_bit  output  4×1  stochastic bits; forced 0 when o_isgen=0.
- o_done  output  1  one-cycle pulse after the last bit or after an abort.
- o_busy  output  1  high in GEN and DONE.

## Operation
- States: IDLE, GEN, DONE. Encoding is left to the implementation.
- IDLE → GEN when i_start_sng=1 and i_stop_sng=0. The transition latches i_x_sng into x_r, i_len_sng into len_r, SEED into r and 0 into cnt.
- GEN:
  - Lane k bit = ({1'b0,rk} < ({x_r[k][3]^1, x_r[k][2:0]}) ), a 5-bit unsigned compare; the right-hand side is x+8, range 0..15.
  - Each cycle r advances one step and cnt increments.
  - GEN → DONE when cnt == len_r, or when i_stop_sng=1. Stop takes priority; the bit in the stop cycle is still valid.
- DONE → IDLE unconditionally.
- RNG: 4-bit de Bruijn sequence, fb = r[3]^r[2]^(r[2:0]==3'b000), next r = {r[2:0], fb}. It must visit all 16 states in 16 steps.
- i_start_sng is ignored in GEN and DONE. No queuing.
- i_x_sng and i_len_sng may change freely after the start cycle.
- Full-period property: for L=16 each lane emits exactly x+8 ones. x=−8 gives all zeros and x=7 gives 15 ones.
- For L<16 the count is whatever the RNG prefix produces. No exactness is guaranteed.

## Timing
- Reset values: state=IDLE, r=SEED, cnt=0, x_r=0, len_r=0.
- Output reset values: o_isgen=0, o_sn_bit=0, o_done=0, o_busy=0.
- A start accepted at edge E0 gives o_isgen=1 during cycles E0..E0+L−1, exactly L bit-cycles. o_done=1 in the cycle after the last bit, then IDLE.
- o_isgen and o_busy are decoded from registered state. o_sn_bit is combinational from registered r and x_r, gated by GEN. No combinational path exists from any input to any output.
- Back-to-back streams: the earliest next start is accepted in the first IDLE cycle after DONE, so the minimum period is L+2 cycles.
- Simultaneous start and stop in IDLE: stop wins and no stream starts.
- Reset asserted mid-stream: all outputs go to reset values immediately (asynchronously). No o_done pulse is issued.

## Configuration
- SC_LANE_DECORR_EN defined: lane k uses rk = r rotated left by k bits. Lanes are decorrelated and each lane remains a full permutation over 16 cycles.
- SC_LANE_DECORR_EN undefined: all lanes use rk = r. Streams are maximally correlated, so lanes with equal x emit identical bits. This mode is used for AND/OR min/max downstream.
- The full-period exact-count property holds in both modes.

## Test plan
- Reset, then x={7,0,−1,−8}, len=15, start pulse → o_isgen high 16 cycles; ones counts {15,8,7,0}; o_done one cycle later; up/down sums {14,0,−2,−16}.
- len=3, x=3 on all lanes → exactly 4 valid cycles; o_done on the 5th cycle; o_sn_bit=0 outside the window.
- Stop asserted in the 6th GEN cycle → 6 valid bits, o_done in the next cycle, then IDLE; a start in the same cycle as the stop in IDLE produces no stream.
- Start re-pulsed during GEN and operands changed mid-stream → no effect on bit counts or length.
- Reset asserted in the 9th GEN cycle → all outputs 0 asynchronously; after release, a new start produces a correct 16-cycle stream.
- Both macro settings, all lanes x=2, len=15 → the correlated build gives identical lane streams; the decorrelated build gives non-identical streams; both give 10 ones per lane.

Source files
------------

// File: rtl/sc_stream_gen.sv
// Binary-to-stochastic stream generator: four bipolar lanes compared against a 4-bit de Bruijn RNG.
// Define SC_LANE_DECORR_EN to rotate the RNG per lane; leave it undefined for fully correlated lanes.
module sc_stream_gen #(
  parameter logic [3:0] SEED = 4'b0000
) (
  input  logic            i_clk_sng,
  input  logic            i_rst_sng,
  input  logic            i_start_sng,
  input  logic            i_stop_sng,
  input  logic [3:0][3:0] i_x_sng,
  input  logic [3:0]      i_len_sng,
  output logic            o_isgen,
  output logic [3:0]      o_sn_bit,
  output logic            o_done,
  output logic            o_busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GEN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]      state;
  logic [3:0]      r;
  logic [3:0]      cnt;
  logic [3:0][3:0] x_r;
  logic [3:0]      len_r;

  // The all-zero term splices 0000 into the maximal-length cycle, giving all 16 states.
  function automatic logic [3:0] rng_next(input logic [3:0] v);
    logic fb;
    fb = v[3] ^ v[2] ^ (v[2:0] == 3'b000);
    return {v[2:0], fb};
  endfunction

  always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
    if (i_rst_sng) begin
      state <= ST_IDLE;
      r     <= SEED;
      cnt   <= 4'd0;
      x_r   <= '0;
      len_r <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start_sng && !i_stop_sng) begin
            state <= ST_GEN;
            x_r   <= i_x_sng;
            len_r <= i_len_sng;
            r     <= SEED;
            cnt   <= 4'd0;
          end
        end
        ST_GEN: begin
          r   <= rng_next(r);
          cnt <= cnt + 4'd1;
          if (i_stop_sng || (cnt == len_r)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_isgen = (state == ST_GEN);
  assign o_done  = (state == ST_DONE);
  assign o_busy  = (state == ST_GEN) || (state == ST_DONE);

  // Offset-binary threshold: flipping the sign bit maps x in -8..7 onto 0..15.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [3:0] rk;
`ifdef SC_LANE_DECORR_EN
    assign rk = (r << k) | (r >> (4 - k));
`else
    assign rk = r;
`endif
    assign o_sn_bit[k] = o_isgen &
                         ({1'b0, rk} < {1'b0, ~x_r[k][3], x_r[k][2:0]});
  end

endmodule
